// File: rtl/x_delay_line_pkg.sv
// Shared types and widths for the delay-line measurement controller.
// Holds the FSM state encoding plus the tap, count, sum and average widths.
// Optional bubble detection is enabled by defining X_DELAY_LINE_CTRL_BUBBLE_EN.
package x_delay_line_pkg;

  // Width of the registered tap vector coming back from the delay line
  localparam int TAP_W = 32;
  // Popcount of one capture: 0..32 needs 6 bits
  localparam int CNT_W = 6;
  // Accumulator: worst case 32 taps * 256 samples = 8192, fits in 14 bits
  localparam int SUM_W = 14;
  // Average is at most 32, fits in 6 bits
  localparam int AVG_W = 6;
  // Settle wait counter, SETTLE_CYC up to 15
  localparam int SET_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/x_delay_line_popcnt.sv
// Combinational population count of one 32-bit tap difference vector.
// Zero latency; purely combinational, no flow control.
// Output range 0..32.
module x_delay_line_popcnt
  import x_delay_line_pkg::*;
(
  input  logic [TAP_W-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Sum the set bits of the difference vector
  always_comb begin
    count_o = '0;
    for (int i = 0; i < TAP_W; i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/x_delay_line_ctrl.sv
// Delay-line measurement controller: launches NUM_SAMPLES toggles, counts flipped taps, averages.
// Latency NUM_SAMPLES*(SETTLE_CYC+2)+1 cycles from accepted request to o_valid.
// Result held in DONE until i_ready; requests while busy are dropped. Bubble flag needs X_DELAY_LINE_CTRL_BUBBLE_EN.
module x_delay_line_ctrl
  import x_delay_line_pkg::*;
#(
  parameter int NUM_SAMPLES = 8,
  parameter int SETTLE_CYC  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  output logic             o_busy,
  output logic             o_start,
  input  logic [TAP_W-1:0] i_data,
  output logic [SUM_W-1:0] o_sum,
  output logic [AVG_W-1:0] o_avg,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_bubble
);

  localparam int LOG2_N = $clog2(NUM_SAMPLES);
  localparam int SMP_W  = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(NUM_SAMPLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_e             state_q;
  logic [TAP_W-1:0]   base_q;
  logic [SUM_W-1:0]   acc_q;
  logic [SUM_W-1:0]   acc_d;
  logic [SMP_W-1:0]   smp_q;
  logic [SET_W-1:0]   set_q;
  logic               start_q;
  logic               busy_q;
  logic               valid_q;
  logic [TAP_W-1:0]   diff;
  logic [CNT_W-1:0]   cnt;

  // XOR against the launch baseline makes the count independent of toggle polarity
  assign diff = i_data ^ base_q;

  x_delay_line_popcnt u_popcnt (
    .data_i  (diff),
    .count_o (cnt)
  );

  assign acc_d = acc_q + SUM_W'(cnt);

  // Measurement sequencer with registered handshake/strobe outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      acc_q   <= '0;
      smp_q   <= '0;
      set_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            smp_q   <= '0;
          end
        end
        LAUNCH: begin
          base_q  <= i_data;
          set_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (set_q == SET_LAST) begin
            state_q <= CAPTURE;
          end else begin
            set_q <= set_q + 1'b1;
          end
        end
        CAPTURE: begin
          acc_q <= acc_d;
          if (smp_q == SMP_LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            smp_q   <= smp_q + 1'b1;
            state_q <= LAUNCH;
            start_q <= 1'b1;
          end
        end
        DONE: begin
          // A request coinciding with this handshake is not taken; IDLE sees it next cycle
          if (valid_q && i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_start = start_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_sum   = acc_q;
  assign o_avg   = AVG_W'(acc_q >> LOG2_N);

`ifdef X_DELAY_LINE_CTRL_BUBBLE_EN
  logic             bubble_q;
  logic [TAP_W-1:0] diff_inc;
  logic             bubble_hit;

  // A clean thermometer diff is 2^n-1; adding one then clears every set bit
  assign diff_inc   = diff + 1'b1;
  assign bubble_hit = |(diff & diff_inc);

  // Sticky bubble flag, cleared when a new request is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bubble_q <= 1'b0;
    end else if (state_q == IDLE && i_req) begin
      bubble_q <= 1'b0;
    end else if (state_q == CAPTURE && bubble_hit) begin
      bubble_q <= 1'b1;
    end
  end

  assign o_bubble = bubble_q;
`else
  assign o_bubble = 1'b0;
`endif

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
module tb_x_delay_line_ctrl;

  localparam int N   = 8;
  localparam int S   = 2;
  localparam int LAT = N * (S + 2) + 1;
  localparam int N2   = 256;
  localparam int S2   = 1;
  localparam int LAT2 = N2 * (S2 + 2) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] data = '0;
  logic        ready = 1'b0;
  logic        busy, start, valid, bubble;
  logic [13:0] sum;
  logic [5:0]  avg;

  logic        req2 = 1'b0;
  logic [31:0] data2 = '0;
  logic        ready2 = 1'b0;
  logic        busy2, start2, valid2, bubble2;
  logic [13:0] sum2;
  logic [5:0]  avg2;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] base_a [0:255];
  logic [31:0] cap_a  [0:255];

  int          obs_lat, obs_start_bad, obs_hold_bad;
  logic [13:0] obs_sum, obs_idle_sum;
  logic [5:0]  obs_avg;
  logic        obs_bub, obs_idle_busy, obs_idle_valid, obs_idle2_busy;

  always #5 clk = ~clk;

  x_delay_line_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_busy(busy), .o_start(start),
    .i_data(data), .o_sum(sum), .o_avg(avg), .o_valid(valid), .i_ready(ready),
    .o_bubble(bubble)
  );

  x_delay_line_ctrl #(.NUM_SAMPLES(N2), .SETTLE_CYC(S2)) dut256 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .o_busy(busy2), .o_start(start2),
    .i_data(data2), .o_sum(sum2), .o_avg(avg2), .o_valid(valid2), .i_ready(ready2),
    .o_bubble(bubble2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A diff is a clean thermometer if its set bits are exactly the lowest n bits
  function automatic bit is_therm(input logic [31:0] d);
    int n;
    logic [63:0] mask;
    n = $countones(d);
    mask = (64'd1 << n) - 64'd1;
    return d == mask[31:0];
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += $countones(base_a[i] ^ cap_a[i]);
    return s;
  endfunction

  function automatic bit model_bubble();
    bit b = 1'b0;
`ifdef X_DELAY_LINE_CTRL_BUBBLE_EN
    for (int i = 0; i < N; i++) if (!is_therm(base_a[i] ^ cap_a[i])) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic logic [31:0] therm(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  // Drives one full request on the default instance and records what it observed
  task automatic run_meas(input int hold, input bit req_in_done, input bit rand_req);
    int t, pos, k;
    bit exp_start;
    obs_lat = -1; obs_start_bad = 0; obs_hold_bad = 0;
    req = 1'b1; data = $urandom; ready = 1'($urandom);
    step();
    t = 1;
    while (t <= LAT + 4) begin
      pos = (t - 1) % (S + 2);
      k   = (t - 1) / (S + 2);
      exp_start = (t < LAT) && (pos == 0);
      if (start !== exp_start || busy !== 1'b1) obs_start_bad++;
      if (valid === 1'b1) begin
        obs_lat = t;
        break;
      end
      if (pos == 0) data = base_a[k];
      else if (pos == S + 1) data = cap_a[k];
      else data = $urandom;
      req   = rand_req ? 1'($urandom) : 1'b0;
      ready = 1'($urandom);
      step();
      t++;
    end
    if (obs_lat < 0) return;
    obs_sum = sum; obs_avg = avg; obs_bub = bubble;
    for (int h = 0; h < hold; h++) begin
      ready = 1'b0;
      req   = rand_req ? 1'($urandom) : 1'b0;
      data  = $urandom;
      step();
      if (valid !== 1'b1 || sum !== obs_sum || avg !== obs_avg || bubble !== obs_bub)
        obs_hold_bad++;
    end
    ready = 1'b1; req = req_in_done;
    step();
    obs_idle_busy = busy; obs_idle_valid = valid; obs_idle_sum = sum;
    ready = 1'b0; req = 1'b0;
    step();
    obs_idle2_busy = busy;
  endtask

  task automatic test_reset();
    vectors++;
    if ({busy, start, valid, bubble} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, start, valid, bubble});
    end
    vectors++;
    if (sum !== 14'd0 || avg !== 6'd0) begin
      errors++;
      $display("FAIL reset_sum: got sum %0d avg %0d expected 0 0", sum, avg);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) begin base_a[i] = 32'h0; cap_a[i] = 32'h0000_00FF; end
    run_meas(0, 1'b0, 1'b0);
    vectors++;
    if (obs_lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", obs_lat); end
    vectors++;
    if (obs_sum !== 14'd64 || obs_avg !== 6'd8 || obs_bub !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got sum %0d avg %0d bub %0d expected 64 8 0", obs_sum, obs_avg, obs_bub);
    end
    vectors++;
    if (obs_start_bad !== 0) begin errors++; $display("FAIL basic_start: got %0d bad cycles expected 0", obs_start_bad); end
  endtask

  task automatic test_inverted();
    for (int i = 0; i < N; i++) begin base_a[i] = 32'hFFFF_FFFF; cap_a[i] = 32'hFFFF_F000; end
    run_meas(0, 1'b0, 1'b0);
    vectors++;
    if (obs_sum !== 14'd96 || obs_avg !== 6'd12) begin
      errors++;
      $display("FAIL inverted_result: got sum %0d avg %0d expected 96 12", obs_sum, obs_avg);
    end
  endtask

  task automatic test_random();
    int es;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        base_a[i] = ($urandom_range(1) == 1) ? 32'hFFFF_FFFF : 32'h0;
        if ($urandom_range(7) == 0) cap_a[i] = $urandom;
        else cap_a[i] = base_a[i] ^ therm($urandom_range(32));
      end
      es = model_sum();
      run_meas($urandom_range(3), 1'b0, 1'b1);
      vectors++;
      if (obs_lat !== LAT) begin errors++; $display("FAIL random_latency: got %0d expected %0d", obs_lat, LAT); end
      vectors++;
      if (obs_sum !== 14'(es) || obs_avg !== 6'(es >> 3) || obs_bub !== model_bubble()) begin
        errors++;
        $display("FAIL random_result: got sum %0d avg %0d bub %0d expected %0d %0d %0d",
                 obs_sum, obs_avg, obs_bub, es, es >> 3, model_bubble());
      end
      vectors++;
      if (obs_idle2_busy !== 1'b0 || obs_start_bad !== 0) begin
        errors++;
        $display("FAIL random_no_queue: got busy %0d startbad %0d expected 0 0", obs_idle2_busy, obs_start_bad);
      end
    end
  endtask

  task automatic test_handshake();
    for (int i = 0; i < N; i++) begin base_a[i] = 32'h0; cap_a[i] = therm(i + 3); end
    run_meas(10, 1'b1, 1'b1);
    vectors++;
    if (obs_hold_bad !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", obs_hold_bad); end
    vectors++;
    if (obs_idle_busy !== 1'b0 || obs_idle_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_to_idle: got busy %0d valid %0d expected 0 0", obs_idle_busy, obs_idle_valid);
    end
    vectors++;
    if (obs_idle_sum !== 14'(model_sum())) begin
      errors++;
      $display("FAIL idle_hold_sum: got %0d expected %0d", obs_idle_sum, model_sum());
    end
    vectors++;
    if (obs_idle2_busy !== 1'b0) begin errors++; $display("FAIL req_in_done_ignored: got busy %0d expected 0", obs_idle2_busy); end
  endtask

  task automatic test_bubble();
    bit eb;
    for (int i = 0; i < N; i++) begin base_a[i] = 32'h0; cap_a[i] = 32'h0000_000F; end
    cap_a[4] = 32'h0000_00F7;
    eb = model_bubble();
    run_meas(0, 1'b0, 1'b0);
    vectors++;
    if (obs_bub !== eb || obs_sum !== 14'(model_sum())) begin
      errors++;
      $display("FAIL bubble_set: got bub %0d sum %0d expected %0d %0d", obs_bub, obs_sum, eb, model_sum());
    end
    cap_a[4] = 32'h0000_000F;
    run_meas(0, 1'b0, 1'b0);
    vectors++;
    if (obs_bub !== 1'b0 || obs_sum !== 14'd32) begin
      errors++;
      $display("FAIL bubble_clear: got bub %0d sum %0d expected 0 32", obs_bub, obs_sum);
    end
  endtask

  task automatic test_midreset();
    int pos, k;
    for (int i = 0; i < N; i++) begin base_a[i] = 32'h0; cap_a[i] = 32'h0000_FFFF; end
    req = 1'b1;
    step();
    for (int t = 1; t < 10; t++) begin
      pos = (t - 1) % (S + 2);
      k   = (t - 1) / (S + 2);
      if (pos == 0) data = base_a[k];
      else if (pos == S + 1) data = cap_a[k];
      else data = $urandom;
      req = 1'b0;
      step();
    end
    vectors++;
    if (busy !== 1'b1 || sum !== 14'd32) begin
      errors++;
      $display("FAIL pre_reset: got busy %0d sum %0d expected 1 32", busy, sum);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, start, valid, bubble, sum, avg} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got busy %0d valid %0d sum %0d avg %0d expected all 0", busy, valid, sum, avg);
    end
    step();
    rst = 1'b0;
    step();
    vectors++;
    if ({busy, start, valid, sum} !== '0) begin
      errors++;
      $display("FAIL midreset_idle: got busy %0d valid %0d sum %0d expected 0 0 0", busy, valid, sum);
    end
    for (int i = 0; i < N; i++) cap_a[i] = 32'h0000_0007;
    run_meas(0, 1'b0, 1'b0);
    vectors++;
    if (obs_lat !== LAT || obs_sum !== 14'd24 || obs_avg !== 6'd3) begin
      errors++;
      $display("FAIL after_reset: got lat %0d sum %0d avg %0d expected %0d 24 3", obs_lat, obs_sum, obs_avg, LAT);
    end
  endtask

  task automatic test_max();
    int t, lat, pos;
    lat = -1;
    req2 = 1'b1;
    step();
    t = 1;
    while (t <= LAT2 + 4) begin
      if (valid2 === 1'b1) begin lat = t; break; end
      pos = (t - 1) % (S2 + 2);
      data2 = (pos == 0) ? 32'h0 : 32'hFFFF_FFFF;
      req2 = 1'b0;
      step();
      t++;
    end
    vectors++;
    if (lat !== LAT2) begin errors++; $display("FAIL max_latency: got %0d expected %0d", lat, LAT2); end
    vectors++;
    if (sum2 !== 14'd8192 || avg2 !== 6'd32 || bubble2 !== 1'b0) begin
      errors++;
      $display("FAIL max_result: got sum %0d avg %0d bub %0d expected 8192 32 0", sum2, avg2, bubble2);
    end
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    vectors++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || sum2 !== 14'd8192) begin
      errors++;
      $display("FAIL max_release: got valid %0d busy %0d sum %0d expected 0 0 8192", valid2, busy2, sum2);
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_inverted();
    test_random();
    test_handshake();
    test_bubble();
    test_midreset();
    test_max();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
